// File: rtl/ffq_pkg.sv
// rtl/ffq_pkg.sv - shared constants for the fastest-finger-first round controller
// Purpose: state encoding, display constants and default round timeout.
// Ports: none (package).
package ffq_pkg;

    // Round states; plain 2-bit constants so older tools and netlists can consume them.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    // Digit shown on the 7-segment display when there is no winner.
    localparam logic [3:0] DIGIT_NONE = 4'd0;

    // One second at 50 MHz.
    localparam int DEFAULT_TIMEOUT_CYCLES = 50000000;

endpackage

// File: rtl/ffq_rr_arbiter.sv
// rtl/ffq_rr_arbiter.sv - combinational round-robin arbiter for buzzer requests
// Purpose: pick the first set request at or after ptr_i, ascending with wrap.
// Ports:
//   req_i       [N_PLAYERS-1:0] request vector (one bit per player)
//   ptr_i       [PTR_W-1:0]     index where the search starts
//   grant_idx_o [3:0]           winning player index (0 when no request)
//   any_req_o                   at least one request bit is set
module ffq_rr_arbiter #(
    parameter int N_PLAYERS = 4,
    parameter int PTR_W     = $clog2(N_PLAYERS)
) (
    input  logic [N_PLAYERS-1:0] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [3:0]           grant_idx_o,
    output logic                 any_req_o
);

    always_comb begin
        int          j;
        logic [PTR_W-1:0] jj;
        grant_idx_o = 4'd0;
        any_req_o   = 1'b0;
        // Walk offsets from the largest down so the smallest offset from ptr_i
        // is the last assignment and therefore the winner.
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= N_PLAYERS) begin
                j = j - N_PLAYERS;
            end
            jj = PTR_W'(j);
            if (req_i[jj]) begin
                grant_idx_o = 4'(j);
                any_req_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ffq_round_controller.sv
// rtl/ffq_round_controller.sv - fastest-finger-first quiz round sequencer
// Purpose: arm a round, synchronise buzzers, arbitrate the first valid press
// fairly, and hold the winner (or a timeout) until the host clears.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   buzz          [N_PLAYERS-1:0] raw player buttons, asynchronous to clk
//   host_start    arms a round when high in IDLE
//   host_clear    returns to IDLE from any state (beats host_start)
//   latch_en      high in ARMED
//   winner_valid  high in LOCKED
//   winner_idx    [3:0] zero-based winner, 0 when none
//   digit         [3:0] winner_idx+1 in LOCKED, else 0
//   no_winner     high in EXPIRED
//   false_start   [N_PLAYERS-1:0] players disqualified this round
module ffq_round_controller
    import ffq_pkg::*;
#(
    parameter int N_PLAYERS      = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PLAYERS-1:0] buzz,
    input  logic                 host_start,
    input  logic                 host_clear,
    output logic                 latch_en,
    output logic                 winner_valid,
    output logic [3:0]           winner_idx,
    output logic [3:0]           digit,
    output logic                 no_winner,
    output logic [N_PLAYERS-1:0] false_start
);

    localparam int PTR_W = $clog2(N_PLAYERS);

    logic [N_PLAYERS-1:0] buzz_m_q;
    logic [N_PLAYERS-1:0] buzz_s_q;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_PLAYERS-1:0] false_start_q, false_start_d;
    logic [3:0]           winner_idx_q, winner_idx_d;
    logic [3:0]           digit_q, digit_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [N_PLAYERS-1:0] req;
    logic [3:0]           grant_idx;
    logic                 any_req;

    // Players holding their button when the round was armed stay masked.
    assign req = buzz_s_q & ~false_start_q;

    ffq_rr_arbiter #(
        .N_PLAYERS (N_PLAYERS),
        .PTR_W     (PTR_W)
    ) u_arbiter (
        .req_i       (req),
        .ptr_i       (rr_ptr_q),
        .grant_idx_o (grant_idx),
        .any_req_o   (any_req)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        false_start_d = false_start_q;
        winner_idx_d  = winner_idx_q;
        digit_d       = digit_q;
        rr_ptr_d      = rr_ptr_q;
        if (host_clear) begin
            // rr_ptr survives a clear so fairness carries across rounds.
            state_d       = ST_IDLE;
            false_start_d = '0;
            winner_idx_d  = 4'd0;
            digit_d       = DIGIT_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (host_start) begin
                        state_d       = ST_ARMED;
                        false_start_d = buzz_s_q;
                        cnt_d         = CNT_W'(TIMEOUT_CYCLES - 1);
                    end
                end
                ST_ARMED: begin
                    // A press on the final counter cycle still wins.
                    if (any_req) begin
                        state_d      = ST_LOCKED;
                        winner_idx_d = grant_idx;
                        digit_d      = grant_idx + 4'd1;
                        if (grant_idx == 4'(N_PLAYERS - 1)) begin
                            rr_ptr_d = '0;
                        end else begin
                            rr_ptr_d = PTR_W'(grant_idx + 4'd1);
                        end
                    end else if (cnt_q == '0) begin
                        state_d = ST_EXPIRED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    // LOCKED and EXPIRED hold until host_clear.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buzz_m_q      <= '0;
            buzz_s_q      <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            false_start_q <= '0;
            winner_idx_q  <= 4'd0;
            digit_q       <= DIGIT_NONE;
            rr_ptr_q      <= '0;
        end else begin
            buzz_m_q      <= buzz;
            buzz_s_q      <= buzz_m_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            false_start_q <= false_start_d;
            winner_idx_q  <= winner_idx_d;
            digit_q       <= digit_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    // All outputs come straight from flops.
    assign latch_en     = (state_q == ST_ARMED);
    assign winner_valid = (state_q == ST_LOCKED);
    assign no_winner    = (state_q == ST_EXPIRED);
    assign winner_idx   = winner_idx_q;
    assign digit        = digit_q;
    assign false_start  = false_start_q;

endmodule

// File: doc/ffq_round_controller.md
Name: ffq_round_controller

Overview:
- Sequences one fastest-finger-first quiz round: the host arms the round, player buzzers are synchronised, the first valid press is arbitrated, and the winner is held until the host clears.
- Sits between the player push-buttons/host switches and the display path: drives the latch enable and the BCD digit (1..N, 0 = none) that feeds the 7-segment decoder.
- Replaces the free-running latch enable with a clocked, fair, timeout-bounded round.

Parameters:
- N_PLAYERS, 4, number of buzzer inputs; legal range 2..9 (digit must stay single-decimal).
- TIMEOUT_CYCLES, 50000000, clock cycles an armed round waits before declaring no winner; must be >= 1.
- CNT_W, 26, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- buzz  in  N_PLAYERS  raw player buttons, active-high, asynchronous to clk.
- host_start  in  1  level; arms a round when sampled high in IDLE.
- host_clear  in  1  level; returns to IDLE from any state.
- latch_en  out  1  high only in ARMED (enable for the downstream buzzer latch).
- winner_valid  out  1  high in LOCKED.
- winner_idx  out  4  zero-based winner index; 0 when no winner.
- digit  out  4  winner_idx+1 in LOCKED, else 0; goes straight to the 7-segment decoder.
- no_winner  out  1  high in EXPIRED.
- false_start  out  N_PLAYERS  per-player mask of players disqualified this round.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, rr_ptr=0, sync flops 0, counter 0.
- Input sync: buzz passes through 2 flops (buzz_s). All decisions use buzz_s only. host_start and host_clear are synchronous (no sync stage).
- States and transitions:
  - IDLE: host_start=1 -> ARMED. On that same edge: false_start <= buzz_s (players already holding are masked for the round); counter <= TIMEOUT_CYCLES-1.
  - ARMED: req = buzz_s & ~false_start.
    - req != 0 -> LOCKED; winner chosen by the arbiter; rr_ptr <= (winner+1) mod N_PLAYERS.
    - else counter == 0 -> EXPIRED.
    - else counter decrements.
    - A request and counter==0 in the same cycle: request wins (LOCKED).
  - LOCKED: holds winner_idx/digit steady regardless of buzz. Exit only via host_clear.
  - EXPIRED: no_winner=1, digit=0. Exit only via host_clear.
  - host_clear=1 in any state -> IDLE next edge, clearing false_start and winner outputs. host_clear beats host_start in the same cycle. rr_ptr is NOT cleared by host_clear, only by rst.
- Arbitration (round-robin): search req starting at rr_ptr, ascending with wrap; the first set bit wins. Simultaneous presses are resolved fairly across rounds.
- Latency: a buzz rising edge arriving before clk edge k produces winner_valid=1 after edge k+2 (2 sync edges + 1 state edge). The ARMED-to-LOCKED transition itself is one cycle.
- Masked players: a player masked by false_start cannot win even after releasing and re-pressing; the mask clears only on return to IDLE.
- Outputs are registered (Moore); no combinational path from buzz to any output.
- rst mid-round: aborts immediately to reset values on the next edge.

Decomposition:
- Shared package ffq_pkg:
  - state encoding constants ST_IDLE, ST_ARMED, ST_LOCKED, ST_EXPIRED.
  - DIGIT_NONE = 4'd0.
  - default TIMEOUT_CYCLES.
- One sub-module: ffq_rr_arbiter. Combinational; inputs req[N], ptr; outputs grant_idx and any_req. Instantiated once.
- The two-flop synchroniser stays inline.

Test Plan:
- Reset, then host_start=1 for 1 cycle with buzz=0 -> latch_en=1 next cycle; false_start=0000.
- Armed with rr_ptr=0, buzz=0100 -> exactly 3 edges after the buzz edge: winner_valid=1, winner_idx=2, digit=3, latch_en=0; later buzz=0001 leaves digit=3.
- Simultaneous buzz=1010 at rr_ptr=0 -> winner 1 (digit 2), rr_ptr=2. Clear and re-arm, same 1010 -> winner 3 (digit 4), rr_ptr=0.
- buzz[0] held high while host_start is sampled -> false_start=0001. Pulsing buzz[0] never wins; buzz[2] then wins with digit=3.
- TIMEOUT_CYCLES=5, no buzz -> no_winner=1 on the 6th edge after arming, digit=0. A buzz arriving on the counter==0 cycle instead yields LOCKED.
- host_start and host_clear both high in ARMED -> IDLE with outputs 0. rst asserted in LOCKED -> all outputs 0 and rr_ptr=0 the next edge.
